lsu: RTL and testbench

- Load/store unit directly downstream of the execute stage.
- Consumes the effective address computed by the ALU (rs1 + imm) plus rs2 store data and the one-hot load/store instruction flags.
- Performs the data-memory access over a req/ack handshake and returns sign- or zero-extended load data for register writeback.
- Stalls upstream while an access is outstanding; flags misaligned accesses instead of issuing them.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_if.sv | 23 ++
 rtl/lsu_align.sv | 70 +++++++
 rtl/lsu.sv | 128 ++++++++++++
 tb/tb_lsu.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } lsu_state_t;

   typedef enum logic [2:0] {
      OP_LB,
      OP_LH,
      OP_LW,
      OP_LBU,
      OP_LHU,
      OP_SB,
      OP_SH,
      OP_SW
   } mem_op_t;

   // Byte-lane masks for the 4-lane data bus.
   localparam logic [3:0] LANE_NONE = 4'b0000;
   localparam logic [3:0] LANE_B0   = 4'b0001;
   localparam logic [3:0] LANE_H_LO = 4'b0011;
   localparam logic [3:0] LANE_H_HI = 4'b1100;
   localparam logic [3:0] LANE_W    = 4'b1111;

   function automatic logic is_store(mem_op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request bus between the LSU (master) and the RAM (slave).
interface lsu_if;
   import lsu_pkg::*;

   logic            ram_req_o;
   logic            ram_wr_o;
   logic [XLEN-1:0] ram_addr_o;
   logic [3:0]      ram_byte_en_o;
   logic [XLEN-1:0] ram_wr_data_o;
   logic            ram_ack_i;
   logic [XLEN-1:0] ram_rd_data_i;

   modport master (
      output ram_req_o, ram_wr_o, ram_addr_o, ram_byte_en_o, ram_wr_data_o,
      input  ram_ack_i, ram_rd_data_i
   );

   modport slave (
      input  ram_req_o, ram_wr_o, ram_addr_o, ram_byte_en_o, ram_wr_data_o,
      output ram_ack_i, ram_rd_data_i
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store lane replication, load extraction/extension and
// alignment check for one memory operation.
module lsu_align
   import lsu_pkg::*;
(
   input  mem_op_t         op_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [XLEN-1:0] rd_word_i,
   output logic [3:0]      byte_en_o,
   output logic [XLEN-1:0] wr_data_o,
   output logic [XLEN-1:0] ld_data_o,
   output logic            misaligned_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Select the addressed byte out of the read word.
   always_comb begin
      case (addr_lo_i)
         2'd0:    ld_byte = rd_word_i[7:0];
         2'd1:    ld_byte = rd_word_i[15:8];
         2'd2:    ld_byte = rd_word_i[23:16];
         default: ld_byte = rd_word_i[31:24];
      endcase
   end

   assign ld_half = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

   // Per-op lane enables, write data, load extension and alignment rule.
   always_comb begin
      byte_en_o    = LANE_NONE;
      wr_data_o    = '0;
      ld_data_o    = '0;
      misaligned_o = 1'b0;
      case (op_i)
         OP_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU: ld_data_o = {24'h0, ld_byte};
         OP_LH: begin
            ld_data_o    = {{16{ld_half[15]}}, ld_half};
            misaligned_o = addr_lo_i[0];
         end
         OP_LHU: begin
            ld_data_o    = {16'h0, ld_half};
            misaligned_o = addr_lo_i[0];
         end
         OP_LW: begin
            ld_data_o    = rd_word_i;
            misaligned_o = (addr_lo_i != 2'b00);
         end
         OP_SB: begin
            byte_en_o = LANE_B0 << addr_lo_i;
            wr_data_o = {4{rs2_i[7:0]}};
         end
         OP_SH: begin
            byte_en_o    = addr_lo_i[1] ? LANE_H_HI : LANE_H_LO;
            wr_data_o    = {2{rs2_i[15:0]}};
            misaligned_o = addr_lo_i[0];
         end
         OP_SW: begin
            byte_en_o    = LANE_W;
            wr_data_o    = rs2_i;
            misaligned_o = (addr_lo_i != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from execute, runs it over the RAM
// req/ack bus and returns extended load data for writeback.
//
// Handshakes: ram_req_o stays high with address, write flag, byte enables and
// write data stable until the cycle in which ram_ack_i is seen high; that
// cycle completes the access. stall_o high means upstream must hold its
// instruction; it is high in the accept cycle and every ACCESS cycle.
module lsu
   import lsu_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            valid_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] rs2_rd_data_i,
   input  logic            inst_lb_i,
   input  logic            inst_lh_i,
   input  logic            inst_lw_i,
   input  logic            inst_lbu_i,
   input  logic            inst_lhu_i,
   input  logic            inst_sb_i,
   input  logic            inst_sh_i,
   input  logic            inst_sw_i,
   output logic            stall_o,
   output logic            misalign_o,
   lsu_if.master           bus,
   output logic            rd_wr_en_o,
   output logic [XLEN-1:0] rd_wr_data_o,
   output lsu_state_t      state_o
);

   lsu_state_t      state_q, state_d;
   mem_op_t         dec_op, op_q, al_op;
   logic            any_flag;
   logic [XLEN-1:0] addr_q, rs2_q;
   logic [1:0]      al_addr;
   logic [3:0]      al_be;
   logic [XLEN-1:0] al_wd, al_ld;
   logic            al_mis;
   logic            in_idle, in_access, accept, ack_load;
   logic            misalign_q;
   logic [XLEN-1:0] rd_data_q;

   // Priority decode of the instruction flags: lw > lh > lhu > lb > lbu > sw > sh > sb.
   always_comb begin
      any_flag = 1'b1;
      dec_op   = OP_LB;
      if      (inst_lw_i)  dec_op = OP_LW;
      else if (inst_lh_i)  dec_op = OP_LH;
      else if (inst_lhu_i) dec_op = OP_LHU;
      else if (inst_lb_i)  dec_op = OP_LB;
      else if (inst_lbu_i) dec_op = OP_LBU;
      else if (inst_sw_i)  dec_op = OP_SW;
      else if (inst_sh_i)  dec_op = OP_SH;
      else if (inst_sb_i)  dec_op = OP_SB;
      else                 any_flag = 1'b0;
   end

   assign in_idle   = (state_q == IDLE);
   assign in_access = (state_q == ACCESS);

   // In IDLE the lane logic checks the incoming op; otherwise it works on the latched op.
   assign al_op   = in_idle ? dec_op : op_q;
   assign al_addr = in_idle ? addr_i[1:0] : addr_q[1:0];

   lsu_align u_align (
      .op_i         (al_op),
      .addr_lo_i    (al_addr),
      .rs2_i        (rs2_q),
      .rd_word_i    (bus.ram_rd_data_i),
      .byte_en_o    (al_be),
      .wr_data_o    (al_wd),
      .ld_data_o    (al_ld),
      .misaligned_o (al_mis)
   );

   assign accept   = in_idle && valid_i && any_flag && !al_mis;
   assign ack_load = in_access && bus.ram_ack_i && !is_store(op_q);

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ACCESS;
         ACCESS:  if (bus.ram_ack_i) state_d = is_store(op_q) ? IDLE : RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch the accepted op, misalign pulse and captured load data.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         op_q       <= OP_LB;
         addr_q     <= '0;
         rs2_q      <= '0;
         misalign_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         misalign_q <= in_idle && valid_i && any_flag && al_mis;
         if (accept) begin
            op_q   <= dec_op;
            addr_q <= addr_i;
            rs2_q  <= rs2_rd_data_i;
         end
         if (ack_load) rd_data_q <= al_ld;
      end
   end

   assign bus.ram_req_o     = in_access;
   assign bus.ram_wr_o      = in_access && is_store(op_q);
   assign bus.ram_addr_o    = in_access ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign bus.ram_byte_en_o = in_access ? al_be : LANE_NONE;
   assign bus.ram_wr_data_o = in_access ? al_wd : '0;

   assign stall_o      = accept || in_access;
   assign misalign_o   = misalign_q;
   assign rd_wr_en_o   = (state_q == RESP);
   assign rd_wr_data_o = rd_data_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for the load/store unit with a word-array memory model.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] rs2_rd_data_i = '0;
   logic        inst_lb_i = 0, inst_lh_i = 0, inst_lw_i = 0, inst_lbu_i = 0, inst_lhu_i = 0;
   logic        inst_sb_i = 0, inst_sh_i = 0, inst_sw_i = 0;
   logic        stall_o, misalign_o, rd_wr_en_o;
   logic [31:0] rd_wr_data_o;
   lsu_state_t  state_o;

   lsu_if bus();

   lsu dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n_i),
      .valid_i       (valid_i),
      .addr_i        (addr_i),
      .rs2_rd_data_i (rs2_rd_data_i),
      .inst_lb_i     (inst_lb_i),
      .inst_lh_i     (inst_lh_i),
      .inst_lw_i     (inst_lw_i),
      .inst_lbu_i    (inst_lbu_i),
      .inst_lhu_i    (inst_lhu_i),
      .inst_sb_i     (inst_sb_i),
      .inst_sh_i     (inst_sh_i),
      .inst_sw_i     (inst_sw_i),
      .stall_o       (stall_o),
      .misalign_o    (misalign_o),
      .bus           (bus),
      .rd_wr_en_o    (rd_wr_en_o),
      .rd_wr_data_o  (rd_wr_data_o),
      .state_o       (state_o)
   );

   // Clock.
   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] mem [0:255];

   // Observations of one transaction, filled by run_op.
   logic        obs_req, obs_wr, obs_stable;
   logic [31:0] obs_addr, obs_wd, obs_wb_data;
   logic [3:0]  obs_be;
   int          obs_acc, obs_stall, obs_mis, obs_wb_cnt, obs_wb_lat;

   // ---------------- reference model ----------------
   function automatic logic ref_misaligned(mem_op_t op, logic [31:0] a);
      case (op)
         OP_LH, OP_LHU, OP_SH: return (a % 2) != 0;
         OP_LW, OP_SW:         return (a % 4) != 0;
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(mem_op_t op, logic [31:0] a, logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * (a % 4))) & 32'h0000_00FF;
      h = (w >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
      case (op)
         OP_LB:   return (b >= 32'h80)   ? b - 32'h100   : b;
         OP_LH:   return (h >= 32'h8000) ? h - 32'h10000 : h;
         OP_LBU:  return b;
         OP_LHU:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] ref_be(mem_op_t op, logic [31:0] a);
      case (op)
         OP_SB:   return 4'(1 << (a % 4));
         OP_SH:   return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
         OP_SW:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] ref_wd(mem_op_t op, logic [31:0] d);
      case (op)
         OP_SB:   return (d & 32'hFF)   * 32'h0101_0101;
         OP_SH:   return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic op_is_store(mem_op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_flags(input logic v, input mem_op_t op);
      valid_i    = v;
      inst_lb_i  = v && (op == OP_LB);
      inst_lh_i  = v && (op == OP_LH);
      inst_lw_i  = v && (op == OP_LW);
      inst_lbu_i = v && (op == OP_LBU);
      inst_lhu_i = v && (op == OP_LHU);
      inst_sb_i  = v && (op == OP_SB);
      inst_sh_i  = v && (op == OP_SH);
      inst_sw_i  = v && (op == OP_SW);
   endtask

   // Memory side: apply a write with byte enables to the model.
   task automatic mem_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      for (int l = 0; l < 4; l++)
         if (be[l]) mem[a[9:2]][8*l +: 8] = d[8*l +: 8];
   endtask

   // Present one op for a single cycle and act as memory, acking after 'waits' cycles.
   task automatic run_op(input mem_op_t op, input logic [31:0] a, input logic [31:0] d, input int waits);
      obs_req = 0; obs_wr = 0; obs_stable = 1; obs_addr = '0; obs_wd = '0; obs_be = '0;
      obs_acc = 0; obs_stall = 0; obs_mis = 0; obs_wb_cnt = 0; obs_wb_lat = -1; obs_wb_data = '0;
      @(negedge clk);
      set_flags(1'b1, op);
      addr_i = a;
      rs2_rd_data_i = d;
      #1;
      if (stall_o) obs_stall++;
      for (int cyc = 1; cyc <= waits + 5; cyc++) begin
         @(negedge clk);
         set_flags(1'b0, OP_LB);
         bus.ram_ack_i = 1'b0;
         if (bus.ram_req_o) begin
            if (!obs_req) begin
               obs_req  = 1;
               obs_wr   = bus.ram_wr_o;
               obs_addr = bus.ram_addr_o;
               obs_be   = bus.ram_byte_en_o;
               obs_wd   = bus.ram_wr_data_o;
            end else if (bus.ram_wr_o !== obs_wr || bus.ram_addr_o !== obs_addr ||
                         bus.ram_byte_en_o !== obs_be || bus.ram_wr_data_o !== obs_wd) begin
               obs_stable = 0;
            end
            if (obs_acc == waits) begin
               bus.ram_ack_i = 1'b1;
               if (bus.ram_wr_o) mem_write(bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_wr_data_o);
               else              bus.ram_rd_data_i = mem[bus.ram_addr_o[9:2]];
            end
            obs_acc++;
         end
         if (rd_wr_en_o) begin
            obs_wb_cnt++;
            obs_wb_lat  = cyc;
            obs_wb_data = rd_wr_data_o;
         end
         if (misalign_o) obs_mis++;
         #1;
         if (stall_o) obs_stall++;
      end
      @(negedge clk);
      bus.ram_ack_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      @(negedge clk);
      vectors++;
      if (bus.ram_req_o !== 1'b0 || bus.ram_wr_o !== 1'b0 || bus.ram_addr_o !== 32'h0 ||
          bus.ram_byte_en_o !== 4'h0 || bus.ram_wr_data_o !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_bus: req=%b wr=%b addr=%h be=%b wd=%h, required all 0",
                  bus.ram_req_o, bus.ram_wr_o, bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_wr_data_o);
      end
      vectors++;
      if (stall_o !== 1'b0 || misalign_o !== 1'b0 || rd_wr_en_o !== 1'b0 || rd_wr_data_o !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_out: stall=%b mis=%b wb=%b wbd=%h, required all 0",
                  stall_o, misalign_o, rd_wr_en_o, rd_wr_data_o);
      end
      vectors++;
      if (state_o !== IDLE) begin
         miscompares++;
         $display("FAIL reset_state: got %s, required IDLE", state_o.name());
      end
      rst_n_i = 1'b1;
   endtask

   task automatic test_lw;
      mem[32'h104 >> 2] = 32'hDEAD_BEEF;
      run_op(OP_LW, 32'h0000_0104, 32'h0, 0);
      vectors++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h104 || obs_wr !== 1'b0 || obs_be !== 4'b0000) begin
         miscompares++;
         $display("FAIL lw_req: req=%b addr=%h wr=%b be=%b, required 1 104 0 0000", obs_req, obs_addr, obs_wr, obs_be);
      end
      vectors++;
      if (obs_wb_cnt != 1 || obs_wb_lat != 2 || obs_wb_data !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL lw_wb: count=%0d lat=%0d data=%h, required 1 2 deadbeef", obs_wb_cnt, obs_wb_lat, obs_wb_data);
      end
      vectors++;
      if (obs_stall != 2) begin
         miscompares++;
         $display("FAIL lw_stall: %0d stall cycles, required 2", obs_stall);
      end
   endtask

   task automatic test_load_ext;
      mem_op_t     ops [3] = '{OP_LB, OP_LBU, OP_LHU};
      logic [31:0] adr [3] = '{32'h103, 32'h103, 32'h102};
      logic [31:0] exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
      mem[32'h100 >> 2] = 32'h80FF_0000;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], adr[i], 32'h0, 0);
         vectors++;
         if (obs_wb_cnt != 1 || obs_wb_data !== exp[i] || obs_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL load_ext_%s: count=%0d data=%h addr=%h, required 1 %h 100",
                     ops[i].name(), obs_wb_cnt, obs_wb_data, obs_addr, exp[i]);
         end
      end
   endtask

   task automatic test_store_wait;
      logic [31:0] held;
      held = rd_wr_data_o;
      run_op(OP_SH, 32'h202, 32'h1234_ABCD, 3);
      vectors++;
      if (obs_wr !== 1'b1 || obs_be !== 4'b1100 || obs_wd !== 32'hABCD_ABCD || obs_addr !== 32'h200) begin
         miscompares++;
         $display("FAIL sh_lanes: wr=%b be=%b wd=%h addr=%h, required 1 1100 abcdabcd 200",
                  obs_wr, obs_be, obs_wd, obs_addr);
      end
      vectors++;
      if (obs_acc != 4 || obs_stable !== 1'b1) begin
         miscompares++;
         $display("FAIL sh_hold: access cycles=%0d stable=%b, required 4 1", obs_acc, obs_stable);
      end
      vectors++;
      if (obs_stall != 5 || obs_wb_cnt != 0 || rd_wr_data_o !== held) begin
         miscompares++;
         $display("FAIL sh_side: stall=%0d wb=%0d wbd=%h, required 5 0 %h", obs_stall, obs_wb_cnt, rd_wr_data_o, held);
      end
   endtask

   task automatic test_misalign;
      mem_op_t     ops [2] = '{OP_LW, OP_SH};
      logic [31:0] adr [2] = '{32'h101, 32'h203};
      for (int i = 0; i < 2; i++) begin
         run_op(ops[i], adr[i], 32'hCAFE_F00D, 0);
         vectors++;
         if (obs_req !== 1'b0 || obs_mis != 1 || obs_wb_cnt != 0 || obs_stall != 0) begin
            miscompares++;
            $display("FAIL misalign_%s: req=%b pulses=%0d wb=%0d stall=%0d, required 0 1 0 0",
                     ops[i].name(), obs_req, obs_mis, obs_wb_cnt, obs_stall);
         end
      end
   endtask

   task automatic test_reset_mid_access;
      int wb_seen;
      mem[32'h140 >> 2] = 32'h1357_9BDF;
      @(negedge clk);
      set_flags(1'b1, OP_LW);
      addr_i = 32'h140;
      @(negedge clk);
      set_flags(1'b0, OP_LB);
      vectors++;
      if (bus.ram_req_o !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_pre: req=%b, required 1", bus.ram_req_o);
      end
      rst_n_i = 1'b0;
      #1;
      vectors++;
      if (bus.ram_req_o !== 1'b0 || stall_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_drop: req=%b stall=%b, required 0 0", bus.ram_req_o, stall_o);
      end
      @(negedge clk);
      rst_n_i = 1'b1;
      @(negedge clk);
      vectors++;
      if (state_o !== IDLE) begin
         miscompares++;
         $display("FAIL rst_mid_state: got %s, required IDLE", state_o.name());
      end
      bus.ram_ack_i = 1'b1;
      bus.ram_rd_data_i = mem[32'h140 >> 2];
      wb_seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus.ram_ack_i = 1'b0;
         if (rd_wr_en_o || bus.ram_req_o) wb_seen++;
      end
      vectors++;
      if (wb_seen != 0) begin
         miscompares++;
         $display("FAIL rst_mid_late_ack: %0d cycles with writeback/request, required 0", wb_seen);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] old_word, exp_word;
      old_word = $urandom;
      mem[32'h300 >> 2] = old_word;
      exp_word = {old_word[31:8], 8'h55};
      @(negedge clk);
      set_flags(1'b1, OP_SB);
      addr_i = 32'h300;
      rs2_rd_data_i = 32'h0000_0055;
      @(negedge clk);
      vectors++;
      if (bus.ram_req_o !== 1'b1 || bus.ram_wr_o !== 1'b1 || bus.ram_byte_en_o !== 4'b0001 ||
          bus.ram_wr_data_o !== 32'h5555_5555) begin
         miscompares++;
         $display("FAIL b2b_sb: req=%b wr=%b be=%b wd=%h, required 1 1 0001 55555555",
                  bus.ram_req_o, bus.ram_wr_o, bus.ram_byte_en_o, bus.ram_wr_data_o);
      end
      mem_write(bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_wr_data_o);
      bus.ram_ack_i = 1'b1;
      set_flags(1'b1, OP_LW);
      @(negedge clk);
      bus.ram_ack_i = 1'b0;
      #1;
      vectors++;
      if (bus.ram_req_o !== 1'b0 || stall_o !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_gap: req=%b stall=%b, required 0 1", bus.ram_req_o, stall_o);
      end
      @(negedge clk);
      set_flags(1'b0, OP_LB);
      vectors++;
      if (bus.ram_req_o !== 1'b1 || bus.ram_wr_o !== 1'b0 || bus.ram_addr_o !== 32'h300) begin
         miscompares++;
         $display("FAIL b2b_lw_req: req=%b wr=%b addr=%h, required 1 0 300",
                  bus.ram_req_o, bus.ram_wr_o, bus.ram_addr_o);
      end
      bus.ram_ack_i = 1'b1;
      bus.ram_rd_data_i = mem[bus.ram_addr_o[9:2]];
      @(negedge clk);
      bus.ram_ack_i = 1'b0;
      vectors++;
      if (rd_wr_en_o !== 1'b1 || rd_wr_data_o !== exp_word) begin
         miscompares++;
         $display("FAIL b2b_lw_wb: en=%b data=%h, required 1 %h", rd_wr_en_o, rd_wr_data_o, exp_word);
      end
   endtask

   task automatic test_random;
      mem_op_t     op;
      logic [31:0] a, d, exp_ld;
      int          waits;
      for (int n = 0; n < 60; n++) begin
         op    = mem_op_t'($urandom_range(0, 7));
         a     = $urandom_range(0, 1023);
         d     = $urandom;
         waits = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) mem[a[9:2]] = $urandom;
         exp_ld = ref_load(op, a, mem[a[9:2]]);
         run_op(op, a, d, waits);
         vectors++;
         if (ref_misaligned(op, a)) begin
            if (obs_req !== 1'b0 || obs_mis != 1 || obs_wb_cnt != 0 || obs_stall != 0) begin
               miscompares++;
               $display("FAIL rnd_mis %s a=%h: req=%b pulses=%0d wb=%0d stall=%0d, required 0 1 0 0",
                        op.name(), a, obs_req, obs_mis, obs_wb_cnt, obs_stall);
            end
         end else if (obs_req !== 1'b1 || obs_addr !== (a & ~32'h3) || obs_wr !== op_is_store(op) ||
                      obs_be !== ref_be(op, a) || obs_stable !== 1'b1 || obs_mis != 0 ||
                      obs_acc != waits + 1 || obs_stall != waits + 2) begin
            miscompares++;
            $display("FAIL rnd_req %s a=%h: req=%b addr=%h wr=%b be=%b stable=%b mis=%0d acc=%0d stall=%0d, required be=%b acc=%0d stall=%0d",
                     op.name(), a, obs_req, obs_addr, obs_wr, obs_be, obs_stable, obs_mis, obs_acc, obs_stall,
                     ref_be(op, a), waits + 1, waits + 2);
         end else if (op_is_store(op)) begin
            if (obs_wd !== ref_wd(op, d) || obs_wb_cnt != 0) begin
               miscompares++;
               $display("FAIL rnd_st %s a=%h: wd=%h wb=%0d, required %h 0", op.name(), a, obs_wd, obs_wb_cnt, ref_wd(op, d));
            end
         end else if (obs_wb_cnt != 1 || obs_wb_lat != waits + 2 || obs_wb_data !== exp_ld) begin
            miscompares++;
            $display("FAIL rnd_ld %s a=%h: wb=%0d lat=%0d data=%h, required 1 %0d %h",
                     op.name(), a, obs_wb_cnt, obs_wb_lat, obs_wb_data, waits + 2, exp_ld);
         end
      end
   endtask

   // Test sequence.
   initial begin
      bus.ram_ack_i = 1'b0;
      bus.ram_rd_data_i = '0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      repeat (2) @(negedge clk);
      test_reset;
      test_lw;
      test_load_ext;
      test_store_wait;
      test_misalign;
      test_reset_mid_access;
      test_back_to_back;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
